// File: rtl/uart_tx_arbiter_if.sv
// Requester and UART-core signal bundle for uart_tx_arbiter.
interface uart_tx_arbiter_if #(
  parameter int unsigned NUM_REQ = 4
);
  logic                   ENABLE;
  logic [NUM_REQ-1:0]     REQ_VALID;
  logic [8*NUM_REQ-1:0]   REQ_DATA;
  logic [NUM_REQ-1:0]     REQ_LAST;
  logic [NUM_REQ-1:0]     REQ_READY;
  logic                   TXRDY;
  logic                   UART_CSN;
  logic                   UART_WEN;
  logic [7:0]             UART_DATA;
  logic [NUM_REQ-1:0]     GRANT;
  logic                   LOCKED;
  logic                   BUSY;

  // Arbiter side
  modport master (
    input  ENABLE, REQ_VALID, REQ_DATA, REQ_LAST, TXRDY,
    output REQ_READY, UART_CSN, UART_WEN, UART_DATA, GRANT, LOCKED, BUSY
  );

  // Requester / UART-core side
  modport slave (
    output ENABLE, REQ_VALID, REQ_DATA, REQ_LAST, TXRDY,
    input  REQ_READY, UART_CSN, UART_WEN, UART_DATA, GRANT, LOCKED, BUSY
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin scheduler sharing one COREUART write port
// between NUM_REQ byte streams, with optional packet lock and TXRDY pacing.
module uart_tx_arbiter #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned HOLDOFF     = 2,
  parameter bit          LOCK_PACKET = 1'b1
) (
  input  logic              CLK,
  input  logic              RESET_N,
  uart_tx_arbiter_if.master bus
);
  localparam int unsigned   PW        = $clog2(NUM_REQ);
  localparam logic [3:0]    HOLD_LAST = 4'(HOLDOFF - 1);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

  typedef enum logic [1:0] {IDLE, WRITE, HOLD, WAIT_RDY} state_e;

  state_e             state_q, state_d;
  logic [7:0]         data_q, data_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic               csn_q, csn_d;
  logic               wen_q, wen_d;
  logic               locked_q, locked_d;
  logic [PW-1:0]      owner_q, owner_d;
  logic [PW-1:0]      ptr_q, ptr_d;
  logic [3:0]         cnt_q, cnt_d;

  logic               found;
  logic [PW-1:0]      win;
  logic               accept;
  logic [NUM_REQ-1:0] ready;
  int unsigned        idx;
  logic [PW-1:0]      idx_w;

  // Winner selection: lock owner only, else first valid upward from the RR pointer
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    idx_w = '0;
    if (locked_q) begin
      if (bus.REQ_VALID[owner_q]) begin
        found = 1'b1;
        win   = owner_q;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        idx = 32'(ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        idx_w = PW'(idx);
        if (!found && bus.REQ_VALID[idx_w]) begin
          found = 1'b1;
          win   = idx_w;
        end
      end
    end
  end

  // RESET_N gates the Mealy accept so REQ_READY reads 0 while reset is held
  assign accept = RESET_N && (state_q == IDLE) && bus.ENABLE && bus.TXRDY && found;

  // One-hot accept strobe back to the winning requester
  always_comb begin
    ready = '0;
    if (accept) ready[win] = 1'b1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    grant_d  = grant_q;
    csn_d    = 1'b1;
    wen_d    = 1'b1;
    locked_d = locked_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          data_d       = bus.REQ_DATA[{win, 3'b000} +: 8];
          grant_d      = '0;
          grant_d[win] = 1'b1;
          csn_d        = 1'b0;
          wen_d        = 1'b0;
          state_d      = WRITE;
          if (!locked_q) ptr_d = (win == LAST_IDX) ? '0 : win + 1'b1;
          if (LOCK_PACKET) begin
            if (bus.REQ_LAST[win]) begin
              locked_d = 1'b0;
            end else begin
              locked_d = 1'b1;
              owner_d  = win;
            end
          end
        end
      end
      WRITE: begin
        cnt_d   = '0;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) state_d = WAIT_RDY;
        else                    cnt_d   = cnt_q + 4'd1;
      end
      WAIT_RDY: begin
        if (bus.TXRDY) begin
          state_d = IDLE;
          grant_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers, asynchronously cleared
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q  <= IDLE;
      data_q   <= '0;
      grant_q  <= '0;
      csn_q    <= 1'b1;
      wen_q    <= 1'b1;
      locked_q <= 1'b0;
      owner_q  <= '0;
      ptr_q    <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      grant_q  <= grant_d;
      csn_q    <= csn_d;
      wen_q    <= wen_d;
      locked_q <= locked_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  assign bus.REQ_READY = ready;
  assign bus.UART_CSN  = csn_q;
  assign bus.UART_WEN  = wen_q;
  assign bus.UART_DATA = data_q;
  assign bus.GRANT     = grant_q;
  assign bus.LOCKED    = locked_q;
  assign bus.BUSY      = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Randomized bench for uart_tx_arbiter against a timing-level reference model.
module tb_uart_tx_arbiter;
  localparam int unsigned N         = 4;
  localparam int unsigned HOLDOFF   = 2;
  localparam int          PHASE_LEN = 400;
  localparam int          NPHASE    = 6;

  logic CLK = 1'b0;
  logic RESET_N;
  always #5 CLK = ~CLK;

  uart_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(N),
    .HOLDOFF(HOLDOFF),
    .LOCK_PACKET(1'b1)
  ) dut (
    .CLK(CLK),
    .RESET_N(RESET_N),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit pct(input int p);
    return $urandom_range(0, 99) < p;
  endfunction

  // Reference model: transaction timing derived from accept time, not FSM state
  bit           m_idle;
  int           m_ptr, m_owner, m_wait_from, cyc;
  bit           m_locked, m_strobe;
  logic [7:0]   m_data;
  logic [N-1:0] m_grant;

  logic [N-1:0]   v_drv, l_drv;
  logic [8*N-1:0] d_drv;
  logic           en_drv, tx_drv;
  bit             single_done;
  int             resets_done;

  task automatic model_reset();
    m_idle   = 1'b1;
    m_ptr    = 0;
    m_owner  = 0;
    m_locked = 1'b0;
    m_strobe = 1'b0;
    m_data   = '0;
    m_grant  = '0;
  endtask

  task automatic drive(input int phase);
    for (int i = 0; i < N; i++) d_drv[i*8 +: 8] = 8'($urandom);
    case (phase)
      0: begin
        v_drv = single_done ? '0 : 4'b0100;
        d_drv[23:16] = 8'hA5;
        l_drv = '1; en_drv = 1'b1; tx_drv = 1'b1;
      end
      1: begin
        v_drv = '1; l_drv = '1; en_drv = 1'b1; tx_drv = 1'b1;
      end
      2: begin
        for (int i = 0; i < N; i++) begin v_drv[i] = pct(80); l_drv[i] = pct(30); end
        en_drv = 1'b1; tx_drv = 1'b1;
      end
      3: begin
        for (int i = 0; i < N; i++) begin v_drv[i] = pct(60); l_drv[i] = pct(50); end
        en_drv = 1'b1; tx_drv = pct(10);
      end
      4: begin
        for (int i = 0; i < N; i++) begin v_drv[i] = pct(70); l_drv[i] = pct(40); end
        en_drv = pct(40); tx_drv = pct(85);
      end
      default: begin
        for (int i = 0; i < N; i++) begin v_drv[i] = pct(50); l_drv[i] = pct(50); end
        en_drv = pct(90); tx_drv = pct(85);
      end
    endcase
    bus.REQ_VALID = v_drv;
    bus.REQ_LAST  = l_drv;
    bus.REQ_DATA  = d_drv;
    bus.ENABLE    = en_drv;
    bus.TXRDY     = tx_drv;
  endtask

  task automatic check_reset_values(input string pfx);
    check({pfx, "_csn"},   32'(bus.UART_CSN),  32'd1);
    check({pfx, "_wen"},   32'(bus.UART_WEN),  32'd1);
    check({pfx, "_data"},  32'(bus.UART_DATA), 32'd0);
    check({pfx, "_grant"}, 32'(bus.GRANT),     32'd0);
    check({pfx, "_locked"},32'(bus.LOCKED),    32'd0);
    check({pfx, "_busy"},  32'(bus.BUSY),      32'd0);
    check({pfx, "_ready"}, 32'(bus.REQ_READY), 32'd0);
  endtask

  int           win;
  logic [N-1:0] exp_ready;
  bit           strobe_next, do_rst;

  initial begin
    RESET_N = 1'b0;
    bus.REQ_VALID = '1;
    bus.REQ_LAST  = '1;
    bus.REQ_DATA  = '1;
    bus.ENABLE    = 1'b1;
    bus.TXRDY     = 1'b1;
    single_done   = 1'b0;
    resets_done   = 0;
    cyc           = 0;
    m_wait_from   = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #2;
    check_reset_values("por");
    @(posedge CLK);
    #1;
    RESET_N = 1'b1;

    for (int c = 0; c < PHASE_LEN * NPHASE; c++) begin
      drive(c / PHASE_LEN);
      #1;

      // Expected READY for this cycle from the arbitration rule
      exp_ready = '0;
      win = -1;
      if (m_idle && en_drv && tx_drv) begin
        if (m_locked) begin
          if (v_drv[m_owner]) win = m_owner;
        end else begin
          for (int k = 0; k < N; k++)
            if (win < 0 && v_drv[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
      end
      if (win >= 0) exp_ready[win] = 1'b1;

      check("ready",  32'(bus.REQ_READY), 32'(exp_ready));
      check("csn",    32'(bus.UART_CSN),  32'(!m_strobe));
      check("wen",    32'(bus.UART_WEN),  32'(!m_strobe));
      check("data",   32'(bus.UART_DATA), 32'(m_data));
      check("grant",  32'(bus.GRANT),     32'(m_grant));
      check("locked", 32'(bus.LOCKED),    32'(m_locked));
      check("busy",   32'(bus.BUSY),      32'(!m_idle));

      do_rst = (c / PHASE_LEN == NPHASE - 1) && m_strobe && (resets_done < 4) && pct(25);

      // Advance the model across the coming edge
      strobe_next = 1'b0;
      if (win >= 0) begin
        m_data      = d_drv[win*8 +: 8];
        m_grant     = '0;
        m_grant[win]= 1'b1;
        m_idle      = 1'b0;
        m_wait_from = cyc + HOLDOFF + 2;
        strobe_next = 1'b1;
        if (!m_locked) m_ptr = (win + 1) % N;
        if (l_drv[win]) m_locked = 1'b0;
        else begin m_locked = 1'b1; m_owner = win; end
        if (c / PHASE_LEN == 0) single_done = 1'b1;
      end else if (!m_idle && cyc >= m_wait_from && tx_drv) begin
        m_idle  = 1'b1;
        m_grant = '0;
      end
      m_strobe = strobe_next;
      cyc++;

      if (do_rst) begin
        // Abort during the write strobe; outputs must clear without a clock edge
        RESET_N = 1'b0;
        #1;
        check_reset_values("async_rst");
        model_reset();
        resets_done++;
        @(posedge CLK);
        #1;
        RESET_N = 1'b1;
      end else begin
        @(posedge CLK);
        #1;
      end
    end

    check("single_byte_seen", 32'(single_done), 32'd1);
    check("midop_resets", 32'(resets_done > 0), 32'd1);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
